// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin grant, one operation
// in flight, registered response held until the consumer takes it.
module alu_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [3:0]       req0_op_i,
    input  logic [31:0]      req0_src1_i,
    input  logic [31:0]      req0_src2_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [3:0]       req1_op_i,
    input  logic [31:0]      req1_src1_i,
    input  logic [31:0]      req1_src2_i,
    output logic [3:0]       alu_ctrl_o,
    output logic [31:0]      alu_src1_o,
    output logic [31:0]      alu_src2_o,
    input  logic [31:0]      alu_result_i,
    input  logic             alu_zero_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_id_o,
    output logic [31:0]      resp_result_o,
    output logic             resp_zero_o,
    output logic             resp_err_o,
    output logic [CNT_W-1:0] grant0_cnt_o,
    output logic [CNT_W-1:0] grant1_cnt_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            r_state;
    logic              r_prio;
    logic              r_id;
    logic              r_err;
    logic [3:0]        r_alu_ctrl;
    logic [31:0]       r_alu_src1;
    logic [31:0]       r_alu_src2;
    logic              r_resp_valid;
    logic              r_resp_id;
    logic [31:0]       r_resp_result;
    logic              r_resp_zero;
    logic              r_resp_err;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic              w_gnt_id;
    logic              w_idle;
    logic              w_hs;
    logic [3:0]        w_op;
    logic [31:0]       w_src1;
    logic [31:0]       w_src2;
    logic              w_supp;

    // Lone requester wins outright; on contention the pointer decides.
    always_comb begin
        w_gnt_id = r_prio;
        if (req0_valid_i && !req1_valid_i)
            w_gnt_id = 1'b0;
        else if (req1_valid_i && !req0_valid_i)
            w_gnt_id = 1'b1;
    end

    // rst_n gating keeps both readies low while reset is held.
    assign w_idle       = (r_state == IDLE) && rst_n;
    assign req0_ready_o = w_idle && req0_valid_i && !w_gnt_id;
    assign req1_ready_o = w_idle && req1_valid_i && w_gnt_id;
    assign w_hs         = req0_ready_o || req1_ready_o;

    assign w_op   = w_gnt_id ? req1_op_i   : req0_op_i;
    assign w_src1 = w_gnt_id ? req1_src1_i : req0_src1_i;
    assign w_src2 = w_gnt_id ? req1_src2_i : req0_src2_i;
    assign w_supp = !w_op[3] || (w_op == 4'b1011) || (w_op == 4'b1110) || (w_op == 4'b1111);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_prio        <= 1'b0;
            r_id          <= 1'b0;
            r_err         <= 1'b0;
            r_alu_ctrl    <= '0;
            r_alu_src1    <= '0;
            r_alu_src2    <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
            r_resp_err    <= 1'b0;
            r_cnt0        <= '0;
            r_cnt1        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_id       <= w_gnt_id;
                        r_err      <= !w_supp;
                        r_prio     <= !w_gnt_id;
                        r_alu_ctrl <= w_supp ? w_op   : 4'b0000;
                        r_alu_src1 <= w_supp ? w_src1 : '0;
                        r_alu_src2 <= w_supp ? w_src2 : '0;
                        if (!w_gnt_id && (r_cnt0 != '1))
                            r_cnt0 <= r_cnt0 + 1'b1;
                        if (w_gnt_id && (r_cnt1 != '1))
                            r_cnt1 <= r_cnt1 + 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_alu_ctrl    <= '0;
                    r_alu_src1    <= '0;
                    r_alu_src2    <= '0;
                    r_resp_valid  <= 1'b1;
                    r_resp_id     <= r_id;
                    r_resp_err    <= r_err;
                    r_resp_result <= r_err ? '0 : alu_result_i;
                    r_resp_zero   <= r_err ? 1'b0 : alu_zero_i;
                    r_state       <= RESP;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_ctrl_o    = r_alu_ctrl;
    assign alu_src1_o    = r_alu_src1;
    assign alu_src2_o    = r_alu_src2;
    assign resp_valid_o  = r_resp_valid;
    assign resp_id_o     = r_resp_id;
    assign resp_result_o = r_resp_result;
    assign resp_zero_o   = r_resp_zero;
    assign resp_err_o    = r_resp_err;
    assign grant0_cnt_o  = r_cnt0;
    assign grant1_cnt_o  = r_cnt1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the shared port, expected responses queued
// at issue and popped by a monitor whenever a response handshake occurs.
module tb_alu_arbiter;

    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]    req0_op, req1_op, alu_ctrl;
    logic [31:0]   req0_src1, req0_src2, req1_src1, req1_src2;
    logic [31:0]   alu_src1, alu_src2, alu_result, resp_result;
    logic          alu_zero, resp_valid, resp_ready, resp_id, resp_zero, resp_err;
    logic [CW-1:0] cnt0, cnt1;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(CW)) dut (
        .clk_i(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
        .req0_src1_i(req0_src1), .req0_src2_i(req0_src2),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
        .req1_src1_i(req1_src1), .req1_src2_i(req1_src2),
        .alu_ctrl_o(alu_ctrl), .alu_src1_o(alu_src1), .alu_src2_o(alu_src2),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
        .resp_result_o(resp_result), .resp_zero_o(resp_zero), .resp_err_o(resp_err),
        .grant0_cnt_o(cnt0), .grant1_cnt_o(cnt1)
    );

    // Stand-in for the shared ALU
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_src1 + alu_src2;
            4'b0001: alu_result = alu_src1 - alu_src2;
            4'b0010: alu_result = alu_src1 & alu_src2;
            4'b0011: alu_result = alu_src1 | alu_src2;
            4'b0100: alu_result = alu_src1 ^ alu_src2;
            4'b0101: alu_result = alu_src1 << alu_src2[4:0];
            4'b0110: alu_result = alu_src1 >> alu_src2[4:0];
            4'b0111: alu_result = $signed(alu_src1) >>> alu_src2[4:0];
            4'b1011: alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
            4'b1110: alu_result = alu_src1 - alu_src2;
            4'b1111: alu_result = {31'd0, alu_src1 == alu_src2};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=id%0d/%0h required=none", resp_id, resp_result);
            end else begin
                e = q.pop_front();
                chk("resp_id", {31'd0, resp_id}, {31'd0, e.id});
                chk("resp_result", resp_result, e.res);
                chk("resp_zero", {31'd0, resp_zero}, {31'd0, e.zero});
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            end
        end
    end

    // Entered and left at posedge+1; returns in the ISSUE cycle.
    task automatic do_issue(input logic id, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input logic ez,
                            input logic ee, output int waited);
        exp_t e;
        e.id = id; e.res = er; e.zero = ez; e.err = ee;
        q.push_back(e);
        if (id) begin
            req1_op = op; req1_src1 = a; req1_src2 = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_src1 = a; req0_src2 = b; req0_valid = 1'b1;
        end
        waited = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) chk("ready_timeout", 32'(waited), 32'd0);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic tail_resp();
        @(posedge clk); #1;
        chk("resp_valid_n2", {31'd0, resp_valid}, 32'd1);
        chk("alu_ctrl_resp", {28'd0, alu_ctrl}, 32'd0);
        chk("alu_src1_resp", alu_src1, 32'd0);
        @(posedge clk); #1;
        chk("resp_valid_done", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int gcnt;
        int gcyc[4];
        logic gid[4];

        rst_n = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_src1 = '0; req0_src2 = '0;
        req1_valid = 1'b0; req1_op = '0; req1_src1 = '0; req1_src2 = '0;
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        #1;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_alu_src1", alu_src1, 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;

        // Single add 5+7, handshake on first edge after reset release
        do_issue(1'b0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, w);
        chk("first_hs_wait", 32'(w), 32'd0);
        chk("issue_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("issue_src1", alu_src1, 32'd5);
        chk("issue_src2", alu_src2, 32'd7);
        chk("issue_ready0", {31'd0, req0_ready}, 32'd0);
        chk("issue_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("cnt0_after_one", 32'(cnt0), 32'd1);
        tail_resp();

        // Contention: fresh reset so the pointer favours requester 0
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            exp_t e;
            for (int k = 0; k < 4; k++) begin
                e.id = k[0]; e.res = k[0] ? 32'd99 : 32'd17; e.zero = 1'b0; e.err = 1'b0;
                q.push_back(e);
            end
        end
        req0_op = 4'b0001; req0_src1 = 32'd20;  req0_src2 = 32'd3;
        req1_op = 4'b0001; req1_src1 = 32'd100; req1_src2 = 32'd1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        gcnt = 0;
        for (int i = 0; i < 16 && gcnt < 4; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                gid[gcnt]  = req1_ready;
                gcyc[gcnt] = i;
                gcnt++;
            end
            @(posedge clk);
        end
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_grants", 32'(gcnt), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant_id", {31'd0, gid[k]}, 32'(k % 2));
            chk("rr_interval", 32'(gcyc[k] - gcyc[0]), 32'(3 * k));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rr_cnt0", 32'(cnt0), 32'd2);
        chk("rr_cnt1", 32'(cnt1), 32'd2);
        chk("rr_drained", 32'(q.size()), 32'd0);

        // Zero flag from requester 1
        do_issue(1'b1, 4'b1110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, w);
        tail_resp();
        do_issue(1'b1, 4'b1111, 32'd9, 32'd9, 32'd1, 1'b0, 1'b0, w);
        tail_resp();

        // Unsupported op
        do_issue(1'b0, 4'b1000, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, w);
        chk("err_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("err_alu_src1", alu_src1, 32'd0);
        chk("err_alu_src2", alu_src2, 32'd0);
        tail_resp();

        // Backpressure with requester 0 waiting
        resp_ready = 1'b0;
        do_issue(1'b1, 4'b0010, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, w);
        req0_op = 4'b0000; req0_src1 = 32'd1; req0_src2 = 32'd1; req0_valid = 1'b1;
        #1;
        chk("bp_issue_ready0", {31'd0, req0_ready}, 32'd0);
        chk("bp_issue_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_result", resp_result, 32'h0000F000);
            chk("bp_id", {31'd0, resp_id}, 32'd1);
            chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_done", {31'd0, resp_valid}, 32'd0);

        // Reset while a response is pending
        resp_ready = 1'b0;
        do_issue(1'b0, 4'b0000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, w);
        @(posedge clk); #1;
        chk("pre_rst_valid", {31'd0, resp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_cnt0", 32'(cnt0), 32'd0);
        chk("mid_rst_cnt1", 32'(cnt1), 32'd0);
        void'(q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, resp_valid}, 32'd0);

        // Counter saturation at CNT_W=2
        for (int k = 0; k < 5; k++) begin
            do_issue(1'b0, 4'b0000, 32'(k), 32'd1, 32'(k + 1), 1'b0, 1'b0, w);
            tail_resp();
            chk("sat_cnt0", 32'(cnt0), (k >= 2) ? 32'd3 : 32'(k + 1));
        end
        chk("sat_cnt1", 32'(cnt1), 32'd0);
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, width of each per-requester grant counter.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 reqN_valid_i  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready_o  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_op_i  input  4  ALU_control code from requester N.
REQ-007 reqN_src1_i, reqN_src2_i  input  32 each  operands from requester N.
REQ-008 alu_ctrl_o  output  4  ALU_control driven to the shared ALU.
REQ-009 alu_src1_o, alu_src2_o  output  32 each  operands driven to the shared ALU.
REQ-010 alu_result_i  input  32  ALU result.
REQ-011 alu_zero_i  input  1  ALU zero flag.
REQ-012 resp_valid_o  output  1  response available.
REQ-013 resp_ready_i  input  1  consumer takes the response.
REQ-014 resp_id_o  output  1  requester index owning the response.
REQ-015 resp_result_o  output  32  captured ALU result (0 for error responses).
REQ-016 resp_zero_o  output  1  captured zero flag (0 for error responses).
REQ-017 resp_err_o  output  1  op code was unsupported.
REQ-018 grantN_cnt_o  output  CNT_W  accepted operations of requester N.

Function
REQ-019 FSM states IDLE, ISSUE, RESP; exactly one operation outstanding at any time.
REQ-020 IDLE: reqN_ready_o = 1 only for the granted requester; both ready low in ISSUE and RESP.
REQ-021 Grant: one requester valid -> it wins; both valid -> requester not granted last wins (round robin); pointer starts favouring requester 0.
REQ-022 Handshake reqN_valid_i && reqN_ready_o in IDLE latches op, src1, src2, id; IDLE -> ISSUE.
REQ-023 Supported ops: 0000-0111, 1011, 1110, 1111; all others latched with err flag set.
REQ-024 ISSUE: alu_ctrl_o/alu_src1_o/alu_src2_o driven from latched values for exactly one cycle; resp_result/resp_zero captured from ALU at end of that cycle; ISSUE -> RESP.
REQ-025 Error op: ALU outputs held at 0000/0/0 in ISSUE; resp_result_o = 0, resp_zero_o = 0, resp_err_o = 1.
REQ-026 Outside ISSUE alu_ctrl_o, alu_src1_o, alu_src2_o = 0.
REQ-027 RESP: resp_valid_o = 1, response fields stable until resp_valid_o && resp_ready_i; then -> IDLE.
REQ-028 Latency: accept cycle N, ALU driven cycle N+1, resp_valid_o high from cycle N+2; minimum issue interval 3 cycles.
REQ-029 Requester valid may drop while not granted; no operation latched without handshake.
REQ-030 grantN_cnt_o increments by 1 on each accepted handshake of requester N, saturates at all ones (no wrap); error ops counted.
REQ-031 Round-robin pointer updates only on handshake.

Reset
REQ-032 rst_n low asynchronously forces IDLE, all outputs 0, counters 0, latched operation discarded, pointer favouring requester 0.
REQ-033 Reset mid-ISSUE or mid-RESP drops the operation; no response emitted after release.
REQ-034 First handshake possible in first rising edge after rst_n deasserts.

Verification
REQ-035 Req0 only, op 0000, 5+7, resp_ready_i=1 -> alu_ctrl_o=0000 in cycle N+1, resp_valid_o cycle N+2, resp_result_o=12, resp_id_o=0, grant0_cnt_o=1.
REQ-036 Both valid continuously, op 0001 -> grants alternate 0,1,0,1; each response after 3 cycles; counts 2/2 after four responses.
REQ-037 Req1 op 1110, src1=src2=9 -> resp_zero_o=1; op 1111 same operands -> resp_zero_o=0.
REQ-038 Req0 op 1000 -> resp_err_o=1, resp_result_o=0, ALU outputs 0 throughout.
REQ-039 resp_ready_i low 5 cycles -> resp_valid_o and fields stable, both ready low; completes one cycle after ready rises.
REQ-040 Assert rst_n low during RESP -> resp_valid_o 0 immediately, counters 0; with CNT_W=2, five grants of req0 -> grant0_cnt_o holds 3.
